mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/arb_id_queue.sv | 70 +++++++
 rtl/mem_arbiter.sv | 113 +++++++++++
 tb/tb_mem_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: requester identity and the
// in-order response-tracking entry.
package mem_arbiter_pkg;

  typedef enum logic {
    SRC_INSTR = 1'b0,
    SRC_DATA  = 1'b1
  } src_e;

  typedef struct packed {
    src_e src;
    logic drop;
  } id_entry_t;

endpackage

// File: rtl/arb_id_queue.sv
// Circular FIFO of outstanding-transaction IDs, with a flush that marks
// every queued instruction entry so its response is swallowed.
module arb_id_queue
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           push_i,
  input  src_e                           push_src_i,
  input  logic                           pop_i,
  input  logic                           flush_i,
  output id_entry_t                      head_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  id_entry_t         mem_q [DEPTH];
  id_entry_t         mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push_i) - CW'(pop_i);
    // Stale slots may also get marked; harmless since a push rewrites drop.
    if (flush_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (mem_q[i].src == SRC_INSTR) mem_d[i].drop = 1'b1;
      end
    end
    if (push_i) begin
      mem_d[wr_ptr_q] = '{src: push_src_i, drop: 1'b0};
      wr_ptr_d        = ptr_next(wr_ptr_q);
    end
    if (pop_i) rd_ptr_d = ptr_next(rd_ptr_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch, load/store) arbiter onto one pipelined memory port with
// in-order responses, starvation guard for fetch and fetch-response flush.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned STARVE_LIMIT    = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  input  logic        instr_flush_i,
  output logic        protocol_err_o
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  logic [3:0]    starve_q, starve_d;
  logic          protocol_err_q, protocol_err_d;
  logic          instr_win, accept, pop;
  src_e          push_src;
  id_entry_t     head;
  logic          id_full, id_empty;
  logic [CW-1:0] id_count;

  arb_id_queue #(.DEPTH(MAX_OUTSTANDING)) u_id_queue (
    .clk        (clk),
    .rstn       (rstn),
    .push_i     (accept),
    .push_src_i (push_src),
    .pop_i      (pop),
    .flush_i    (instr_flush_i),
    .head_o     (head),
    .full_o     (id_full),
    .empty_o    (id_empty),
    .count_o    (id_count)
  );

  always_comb begin
    instr_win   = ~data_req_i | (starve_q == 4'(STARVE_LIMIT));
    mem_req_o   = (instr_req_i | data_req_i) & ~id_full;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (mem_req_o) begin
      if (instr_win) begin
        mem_addr_o = instr_addr_i;
        mem_be_o   = 4'hF;
      end else begin
        mem_addr_o  = data_addr_i;
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_wdata_o = data_wdata_i;
      end
    end
    instr_gnt_o = mem_gnt_i & mem_req_o & instr_win;
    data_gnt_o  = mem_gnt_i & mem_req_o & ~instr_win;
    accept      = mem_req_o & mem_gnt_i;
    push_src    = instr_win ? SRC_INSTR : SRC_DATA;

    // A response with nothing outstanding never pops the queue.
    pop            = mem_rvalid_i & ~id_empty;
    instr_rvalid_o = pop & (head.src == SRC_INSTR) & ~head.drop & ~instr_flush_i;
    data_rvalid_o  = pop & (head.src == SRC_DATA) & ~head.drop;
    instr_rdata_o  = mem_rdata_i;
    data_rdata_o   = mem_rdata_i;
    instr_err_o    = mem_err_i & instr_rvalid_o;
    data_err_o     = mem_err_i & data_rvalid_o;

    starve_d = starve_q;
    if (!instr_req_i || instr_gnt_o) starve_d = '0;
    else if (starve_q != 4'(STARVE_LIMIT)) starve_d = starve_q + 4'd1;

    protocol_err_d = protocol_err_q | (mem_rvalid_i & (id_count == '0));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_q       <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      starve_q       <= starve_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  assign protocol_err_o = protocol_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a queue-based
// behavioural model of arbitration and in-order responses.
module tb_mem_arbiter;

  localparam int MAX = 2;
  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        instr_req_i = 1'b0, instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_addr_i = '0, instr_rdata_o;
  logic        data_req_i = 1'b0, data_we_i = 1'b0, data_gnt_o, data_rvalid_o, data_err_o;
  logic [3:0]  data_be_i = '0;
  logic [31:0] data_addr_i = '0, data_wdata_i = '0, data_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0, mem_err_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        instr_flush_i = 1'b0, protocol_err_o;

  mem_arbiter #(.MAX_OUTSTANDING(MAX), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rstn(rstn),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .instr_flush_i(instr_flush_i), .protocol_err_o(protocol_err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard of outstanding transactions: bit1 = drop, bit0 = source (1 = data).
  logic [1:0] exp_q[$];
  int         starve_m = 0;
  bit         perr_m = 1'b0;

  logic        last_ig, last_dg, last_mreq, last_irv, last_drv;
  logic [31:0] last_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cycle(input bit ir, input logic [31:0] ia, input bit dr, input bit dwe,
                       input logic [3:0] dbe, input logic [31:0] da, input logic [31:0] dwd,
                       input bit gnt, input bit rv, input logic [31:0] rd, input bit er,
                       input bit fl);
    bit         full, mreq, iw, ig, dg, pop, e_irv, e_drv;
    logic [1:0] head;
    @(negedge clk);
    instr_req_i = ir;  instr_addr_i = ia;
    data_req_i = dr;   data_we_i = dwe;  data_be_i = dbe;
    data_addr_i = da;  data_wdata_i = dwd;
    mem_gnt_i = gnt;   mem_rvalid_i = rv; mem_rdata_i = rd; mem_err_i = er;
    instr_flush_i = fl;
    #1;
    full  = (exp_q.size() == MAX);
    mreq  = (ir || dr) && !full;
    iw    = !dr || (starve_m == LIM);
    ig    = gnt && mreq && iw;
    dg    = gnt && mreq && !iw;
    pop   = rv && (exp_q.size() > 0);
    head  = pop ? exp_q[0] : 2'b00;
    e_irv = pop && !head[0] && !head[1] && !fl;
    e_drv = pop && head[0] && !head[1];

    check("mem_req", mem_req_o, mreq);
    if (mreq) begin
      check("mem_addr", mem_addr_o, iw ? ia : da);
      check("mem_we", mem_we_o, iw ? 1'b0 : dwe);
      check("mem_be", mem_be_o, iw ? 4'hF : dbe);
      check("mem_wdata", mem_wdata_o, iw ? 32'h0 : dwd);
    end else if (!ir && !dr) begin
      check("idle_addr", mem_addr_o, 32'h0);
      check("idle_be", mem_be_o, 4'h0);
    end
    check("instr_gnt", instr_gnt_o, ig);
    check("data_gnt", data_gnt_o, dg);
    check("instr_rvalid", instr_rvalid_o, e_irv);
    check("data_rvalid", data_rvalid_o, e_drv);
    check("instr_rdata", instr_rdata_o, rd);
    check("data_rdata", data_rdata_o, rd);
    check("instr_err", instr_err_o, er && e_irv);
    check("data_err", data_err_o, er && e_drv);
    check("protocol_err", protocol_err_o, perr_m);

    last_ig = instr_gnt_o;  last_dg = data_gnt_o;  last_mreq = mem_req_o;
    last_irv = instr_rvalid_o;  last_drv = data_rvalid_o;  last_rdata = instr_rdata_o;

    if (rv && exp_q.size() == 0) perr_m = 1'b1;
    if (pop) void'(exp_q.pop_front());
    if (fl) foreach (exp_q[i]) if (!exp_q[i][0]) exp_q[i][1] = 1'b1;
    if (gnt && mreq) exp_q.push_back({1'b0, !iw});
    if (!ir || ig) starve_m = 0;
    else if (starve_m < LIM) starve_m++;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    instr_req_i = 0; instr_addr_i = 0; data_req_i = 0; data_we_i = 0; data_be_i = 0;
    data_addr_i = 0; data_wdata_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
    mem_rdata_i = 0; mem_err_i = 0; instr_flush_i = 0;
    #1;
    check("rst_mem_req", mem_req_o, 1'b0);
    check("rst_gnt", {instr_gnt_o, data_gnt_o}, 2'b00);
    check("rst_rvalid", {instr_rvalid_o, data_rvalid_o}, 2'b00);
    check("rst_addr", mem_addr_o, 32'h0);
    check("rst_be", mem_be_o, 4'h0);
    check("rst_perr", protocol_err_o, 1'b0);
    exp_q.delete();
    starve_m = 0;
    perr_m = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    bit          rv;
    int          rv_pct;
    repeat (2) @(posedge clk);
    do_reset();

    // Both ports hammering with an always-ready memory: D,D,D,D,I repeating.
    for (int i = 0; i < 10; i++) begin
      rv = (exp_q.size() > 0);
      cycle(1, 32'h1000 + i, 1, 1, 4'h3, 32'h2000 + i, 32'hD000 + i, 1, rv, 32'h5000 + i, 0, 0);
      check("pattern_i", last_ig, (i % 5) == 4);
      check("pattern_d", last_dg, (i % 5) != 4);
    end

    // Fill with two fetches; no same-cycle bypass when the first response frees a slot.
    do_reset();
    cycle(1, 32'h10, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    cycle(1, 32'h14, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    cycle(1, 32'h18, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    check("full_no_req", last_mreq, 1'b0);
    cycle(1, 32'h18, 0, 0, 0, 0, 0, 1, 1, 32'h11, 0, 0);
    check("full_pop_no_req", last_mreq, 1'b0);
    check("full_pop_rvalid", last_irv, 1'b1);
    cycle(1, 32'h18, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    check("slot_freed_gnt", last_ig, 1'b1);
    cycle(1, 32'h1C, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    check("refull_no_req", last_mreq, 1'b0);

    // In-order responses routed to their sources.
    do_reset();
    cycle(1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 4'hF, 32'h200, 0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hAAAA, 0, 0);
    check("order_irv", last_irv, 1'b1);
    check("order_irdata", last_rdata, 32'hAAAA);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hBBBB, 1, 0);
    check("order_drv", last_drv, 1'b1);
    check("order_drdata", last_rdata, 32'hBBBB);

    // Flush drops the old fetch but not one accepted in the flush cycle.
    do_reset();
    cycle(1, 32'h300, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    cycle(1, 32'h304, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    check("flush_new_gnt", last_ig, 1'b1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hC0, 0, 0);
    check("flush_silent", last_irv, 1'b0);
    cycle(0, 0, 1, 1, 4'h1, 32'h400, 32'h55, 1, 1, 32'hC1, 0, 0);
    check("flush_new_delivered", last_irv, 1'b1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hC2, 0, 0);
    check("flush_data_delivered", last_drv, 1'b1);

    // Stray response: ignored and sticky protocol error.
    do_reset();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD, 1, 0);
    check("stray_no_rvalid", {last_irv, last_drv}, 2'b00);
    repeat (3) idle();
    check("stray_perr_sticky", protocol_err_o, 1'b1);

    // Reset with two outstanding abandons them.
    do_reset();
    cycle(1, 32'h500, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    cycle(1, 32'h504, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    do_reset();
    cycle(1, 32'h508, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    check("post_rst_req", last_mreq, 1'b1);
    check("post_rst_gnt", last_ig, 1'b1);
    cycle(1, 32'h50C, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    check("post_rst_count1", last_mreq, 1'b1);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) do_reset();
      rv_pct = (exp_q.size() > 0) ? 45 : 1;
      rv = ($urandom_range(0, 99) < rv_pct);
      cycle($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 60,
            $urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom, $urandom,
            $urandom_range(0, 99) < 70, rv, $urandom, $urandom_range(0, 99) < 15,
            $urandom_range(0, 99) < 8);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
